// File: rtl/pattern_serial_tx_if.sv
// Purpose: load/pattern request bus and serial output bus of pattern_serial_tx.
// Latency: none (signal bundle only).
// Backpressure: the source holds load until it sees ready; a load while ready=0 is dropped.
// Ports/signals: load, pattern, len, reps (request side); ready, dout, dout_valid, done (transmitter side).
interface pattern_serial_tx_if #(
    parameter int WIDTH = 8,
    parameter int LENW  = 4,
    parameter int REPW  = 4
);
    logic             load;
    logic [WIDTH-1:0] pattern;
    logic [LENW-1:0]  len;
    logic [REPW-1:0]  reps;
    logic             ready;
    logic             dout;
    logic             dout_valid;
    logic             done;

    // master: the block requesting a pattern and consuming the serial stream
    modport master (
        output load, pattern, len, reps,
        input  ready, dout, dout_valid, done
    );

    // slave: the transmitter
    modport slave (
        input  load, pattern, len, reps,
        output ready, dout, dout_valid, done
    );
endinterface

// File: rtl/pattern_serial_tx.sv
// Purpose: shift a captured bit pattern out MSB-first, repeated reps+1 times back-to-back.
// Latency: load accepted at edge N gives the first bit in cycle N+1; done pulses one cycle after the last bit.
// Backpressure: ready=0 for the whole job; a load while busy is ignored, not queued.
// Ports: clk, rst (sync, active-high), bus (slave modport: load/pattern/len/reps in; ready/dout/dout_valid/done out).
module pattern_serial_tx #(
    parameter int WIDTH = 8,
    parameter int LENW  = 4,
    parameter int REPW  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    pattern_serial_tx_if.slave    bus
);

    typedef enum logic {
        S_IDLE,
        S_SHIFT
    } state_t;

    localparam logic [LENW-1:0]  LEN_MAX = LENW'(WIDTH);
    localparam logic [LENW-1:0]  IDX_ONE = LENW'(1);
    localparam logic [REPW-1:0]  REP_ONE = REPW'(1);
    localparam logic [WIDTH-1:0] BIT_LSB = WIDTH'(1);

    state_t           state_q;
    logic [WIDTH-1:0] pat_q;
    logic [LENW-1:0]  len_q;
    logic [LENW-1:0]  idx_q;
    logic [REPW-1:0]  rep_q;
    logic             ready_q;
    logic             dout_q;
    logic             vld_q;
    logic             done_q;

    logic [LENW-1:0]  len_eff_d;
    logic [LENW-1:0]  idx_d;
    logic [WIDTH-1:0] bit_src_d;
    logic             bit_d;

    // Next bit index and the bit it selects. In IDLE this looks at the live
    // inputs so the first bit can be registered on the accepting edge; in
    // SHIFT it looks only at the captured pattern.
    always_comb begin
        len_eff_d = bus.len;
        if (bus.len == '0 || bus.len > LEN_MAX) begin
            len_eff_d = LEN_MAX;
        end

        bit_src_d = pat_q;
        idx_d     = idx_q - IDX_ONE;
        if (state_q == S_IDLE) begin
            bit_src_d = bus.pattern;
            idx_d     = len_eff_d - IDX_ONE;
        end else if (idx_q == '0) begin
            // wrap to the MSB of the next repetition, no gap
            idx_d = len_q - IDX_ONE;
        end

        bit_d = |(bit_src_d & (BIT_LSB << idx_d));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            pat_q   <= '0;
            len_q   <= '0;
            idx_q   <= '0;
            rep_q   <= '0;
            ready_q <= 1'b1;
            dout_q  <= 1'b0;
            vld_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (bus.load) begin
                        pat_q   <= bus.pattern;
                        len_q   <= len_eff_d;
                        idx_q   <= idx_d;
                        rep_q   <= bus.reps;
                        state_q <= S_SHIFT;
                        ready_q <= 1'b0;
                        vld_q   <= 1'b1;
                        dout_q  <= bit_d;
                    end else begin
                        ready_q <= 1'b1;
                        vld_q   <= 1'b0;
                        dout_q  <= 1'b0;
                    end
                end
                S_SHIFT: begin
                    if (idx_q != '0 || rep_q != '0) begin
                        idx_q  <= idx_d;
                        dout_q <= bit_d;
                        // repeat counter only moves at a pass boundary and never wraps
                        if (idx_q == '0) begin
                            rep_q <= rep_q - REP_ONE;
                        end
                    end else begin
                        state_q <= S_IDLE;
                        ready_q <= 1'b1;
                        vld_q   <= 1'b0;
                        dout_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.ready      = ready_q;
    assign bus.dout       = dout_q;
    assign bus.dout_valid = vld_q;
    assign bus.done       = done_q;

endmodule

// File: tb/tb_pattern_serial_tx.sv
// Purpose: directed bench for pattern_serial_tx with hand-computed serial streams.
// Latency: inputs driven and outputs sampled 1 time unit after each rising edge.
// Backpressure: exercises busy loads, done-cycle loads and reset abort.
module tb_pattern_serial_tx;

    logic clk;
    logic rst;
    int   tests;
    int   failed;

    pattern_serial_tx_if #(.WIDTH(8), .LENW(4), .REPW(4)) bus ();

    pattern_serial_tx #(.WIDTH(8), .LENW(4), .REPW(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // outputs expected while idle: done distinguishes the done cycle
    task automatic chk_idle(input string tag, input logic exp_done);
        chk({tag, ".ready"}, 32'(bus.ready), 32'd1);
        chk({tag, ".valid"}, 32'(bus.dout_valid), 32'd0);
        chk({tag, ".dout"},  32'(bus.dout), 32'd0);
        chk({tag, ".done"},  32'(bus.done), 32'(exp_done));
    endtask

    task automatic chk_bit(input string tag, input logic exp_bit);
        chk({tag, ".valid"}, 32'(bus.dout_valid), 32'd1);
        chk({tag, ".ready"}, 32'(bus.ready), 32'd0);
        chk({tag, ".done"},  32'(bus.done), 32'd0);
        chk({tag, ".dout"},  32'(bus.dout), 32'(exp_bit));
    endtask

    // checks n bits (exp[n-1] first), then stops in the done cycle after checking it
    task automatic run_bits(input string tag, input logic [31:0] exp, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            chk_bit($sformatf("%s.b%0d", tag, i), exp[i]);
            step();
        end
        chk_idle({tag, ".done_cyc"}, 1'b1);
    endtask

    // one-cycle load; returns in the first bit cycle
    task automatic send(input logic [7:0] pat, input logic [3:0] len, input logic [3:0] reps);
        bus.pattern = pat;
        bus.len     = len;
        bus.reps    = reps;
        bus.load    = 1'b1;
        step();
        bus.load    = 1'b0;
    endtask

    initial begin
        tests       = 0;
        failed      = 0;
        rst         = 1'b1;
        bus.load    = 1'b1;
        bus.pattern = 8'h5A;
        bus.len     = 4'd4;
        bus.reps    = 4'd0;

        // reset wins over load
        step();
        chk_idle("rst1", 1'b0);
        step();
        chk_idle("rst2", 1'b0);
        bus.load = 1'b0;
        rst      = 1'b0;
        step();
        chk_idle("post_rst", 1'b0);

        // single pattern 101
        send(8'b0000_0101, 4'd3, 4'd0);
        run_bits("single", 32'b101, 3);
        step();
        chk_idle("single_after", 1'b0);

        // three passes of 101, contiguous
        send(8'b0000_0101, 4'd3, 4'd2);
        run_bits("reps", 32'b101101101, 9);
        step();
        chk_idle("reps_after", 1'b0);

        // len=0 clamps to 8; an 8'hFF load mid-job is dropped
        send(8'hA5, 4'd0, 4'd0);
        for (int i = 7; i >= 0; i--) begin
            if (i == 4) begin
                bus.load    = 1'b1;
                bus.pattern = 8'hFF;
                bus.len     = 4'd8;
            end
            if (i == 1) bus.load = 1'b0;
            chk_bit($sformatf("clamp.b%0d", i), 1'(8'hA5 >> i));
            step();
        end
        chk_idle("clamp.done_cyc", 1'b1);
        for (int k = 0; k < 3; k++) begin
            step();
            chk_idle($sformatf("clamp_after%0d", k), 1'b0);
        end

        // len over maximum (12) also clamps to 8
        send(8'h3C, 4'd12, 4'd0);
        run_bits("over", 32'h3C, 8);
        step();

        // inputs changed right after acceptance have no effect
        send(8'b1000_0010, 4'd3, 4'd0);
        bus.pattern = 8'hFF;
        bus.len     = 4'd8;
        bus.reps    = 4'd3;
        run_bits("stable", 32'b010, 3);
        step();
        chk_idle("stable_after", 1'b0);

        // abort after the 2nd bit of an 8-bit job
        send(8'hA5, 4'd8, 4'd0);
        chk_bit("abort.b7", 1'b1);
        step();
        chk_bit("abort.b6", 1'b0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk_idle("abort_rst", 1'b0);
        step();
        chk_idle("abort_nodone", 1'b0);

        // job after abort: 10 twice
        send(8'b0000_0010, 4'd2, 4'd1);
        run_bits("post_abort", 32'b1010, 4);
        step();

        // load held high: accepted again in the done cycle, one gap cycle only
        bus.pattern = 8'b0000_0110;
        bus.len     = 4'd3;
        bus.reps    = 4'd0;
        bus.load    = 1'b1;
        step();
        run_bits("b2b_a", 32'b110, 3);
        bus.pattern = 8'b0000_0001;
        bus.len     = 4'd2;
        step();
        bus.load = 1'b0;
        run_bits("b2b_b", 32'b01, 2);
        step();
        chk_idle("final", 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/pattern_serial_tx.md
# pattern_serial_tx

Serial pattern transmitter: accepts a parallel bit pattern (length and repeat count) over a ready/load handshake and shifts it out MSB-first, one bit per clock, on a single serial line. It is the source side of our serial sequence-detector blocks and drives their `x` input in the system and on the bench. Repetitions are sent back-to-back with no gap, so patterns that overlap across a repetition boundary can be exercised.

## Interface
- `WIDTH`, 8: maximum pattern length in bits.
- `LENW`, 4: width of `len`; must hold the value `WIDTH`.
- `REPW`, 4: width of `reps`.

- `clk` in 1: single clock; all logic on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `load` in 1: pattern request; accepted only on an edge where `ready`=1.
- `pattern` in WIDTH: bits to send; the first bit sent is `pattern[len_eff-1]`, the last is `pattern[0]`.
- `len` in LENW: number of bits to send. Values 0 and >WIDTH are treated as WIDTH; the result is `len_eff`.
- `reps` in REPW: extra repetitions; total passes = `reps`+1.
- `ready` out 1: block idle and able to accept `load`.
- `dout` out 1: serial data; 0 whenever `dout_valid`=0.
- `dout_valid` out 1: `dout` carries a pattern bit this cycle.
- `done` out 1: one-cycle pulse in the first idle cycle after the final bit.

## Operation
- States are IDLE and SHIFT. All outputs are registered.
- **IDLE:**
  - `ready`=1, `dout_valid`=0, `dout`=0.
  - On `load`=1, capture `pattern`, `len_eff` and `reps` into internal registers.
  - Load the bit index with `len_eff`-1, load the repeat counter with `reps`, then go to SHIFT.
- **SHIFT:**
  - `ready`=0, `dout_valid`=1, `dout`=captured `pattern[bit index]`.
  - Each cycle: if bit index > 0, decrement it.
  - If bit index = 0 and repeat counter > 0: decrement the repeat counter and reload the bit index with `len_eff`-1. There is no idle cycle between passes.
  - If bit index = 0 and repeat counter = 0: go to IDLE and set `done`=1 for one cycle.
- Inputs are sampled only at acceptance. Changes to `pattern`, `len` or `reps` during SHIFT have no effect.
- `load` while `ready`=0 is ignored and not queued.
- A `load` during the `done` cycle is accepted, because `ready`=1 in that cycle.
- Arithmetic is unsigned. The bit index is LENW wide. The repeat counter is REPW wide and never wraps: it decrements only while > 0.
- Total serial length of one job = `len_eff`×(`reps`+1) cycles.

## Timing
- **Reset values:** `ready`=1, `dout`=0, `dout_valid`=0, `done`=0, state IDLE, counters 0.
- **Reset priority:**
  - `rst` has priority over everything, including `load` on the same edge.
  - Asserting `rst` mid-SHIFT aborts the job on the next edge: outputs take their reset values and there is no `done` pulse.
- **Latency:** `load`&`ready` sampled at edge N → first bit on `dout` with `dout_valid`=1 during cycle N+1 (after edge N).
- Each bit is held exactly one cycle.
- The last bit is presented in cycle N+`len_eff`×(`reps`+1). In the following cycle: `done`=1, `ready`=1, `dout_valid`=0.
- **Back-to-back jobs:** with `load` held high, there is exactly one non-valid cycle (the `done` cycle) between jobs.
- `ready` deasserts in the same cycle as the first valid bit.

## Test plan
- **Reset:** hold `rst` for 2 cycles with `load`=1 → `ready`=1, `dout_valid`=0, `dout`=0, `done`=0; no job starts.
- **Single pattern:** `pattern`=8'b0000_0101, `len`=3, `reps`=0, one-cycle `load` → `dout`=1,0,1 on 3 consecutive valid cycles; `done`=1 in the 4th cycle, `ready`=1 in the same cycle.
- **Repeats:** `pattern`=…101, `len`=3, `reps`=2 → `dout`=101101101 over 9 contiguous valid cycles; a single `done` after the 9th bit.
- **Length clamp and busy load:**
  - `len`=0, `pattern`=8'hA5 → 10100101 over 8 cycles.
  - A second `load` with 8'hFF issued mid-job is ignored; no further bits follow `done`.
- **Input stability:** change `pattern`/`len` in the cycle after acceptance → the transmitted bits match the values captured at acceptance.
- **Abort:**
  - Assert `rst` for one cycle after the 2nd bit of a `len`=8 job → next cycle shows reset values and no `done` pulse.
  - A subsequent `load` is accepted normally.
